// File: rtl/trackball_pkg.sv
// Shared constants for the trackball source arbiter.
//  - MODE_* : emulator mode codes, also the index of each source in act[].
//  - ST_*   : arbiter FSM state encoding.
//  - abs8   : two's-complement magnitude of one analog axis (-128 -> 128).
package trackball_pkg;

   localparam int unsigned MODE_W  = 2;
   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned HOLD_W  = 24;
   localparam int unsigned ANA_W   = 8;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned MOUSE_W = 25;

   localparam logic [MODE_W-1:0] MODE_DIG   = 2'd0;
   localparam logic [MODE_W-1:0] MODE_ANA   = 2'd1;
   localparam logic [MODE_W-1:0] MODE_MOUSE = 2'd2;
   localparam logic [MODE_W-1:0] MODE_SNAC  = 2'd3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   // Unsigned magnitude; the 8-bit result keeps -128 as 128 without overflow.
   function automatic logic [ANA_W-1:0] abs8(input logic [ANA_W-1:0] v);
      return v[ANA_W-1] ? ((~v) + ANA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/trackball_activity_detect.sv
// Per-source activity detection for the trackball arbiter.
//  clk, reset_n       : clock, synchronous active-low reset
//  joystick_digital   : {up,down,left,right}
//  joystick_analog    : {y,x}, two's complement
//  mouse_toggle       : PS/2 packet toggle bit
//  v_clk_in, h_clk_in : raw asynchronous SNAC quadrature clocks
//  act                : registered activity flags indexed by MODE_* value
module trackball_activity_detect
   import trackball_pkg::*;
#(
   parameter logic [ANA_W-1:0] ANALOG_DEADZN = 8'd10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIG_W-1:0]     joystick_digital,
   input  logic [2*ANA_W-1:0]   joystick_analog,
   input  logic                 mouse_toggle,
   input  logic                 v_clk_in,
   input  logic                 h_clk_in,
   output logic [NUM_SRC-1:0]   act
);

   logic [DIG_W-1:0]   dig_q;
   logic [2*ANA_W-1:0] ana_q;
   logic               mouse_q;
   logic               in_valid_q;
   logic               mouse_prev;
   logic               mouse_primed;
   logic [1:0]         v_sync;
   logic [1:0]         h_sync;
   logic               v_q;
   logic               h_q;
   logic               v_prev;
   logic               h_prev;
   logic [ANA_W-1:0]   mag_x;
   logic [ANA_W-1:0]   mag_y;
   logic               ana_hit;

   // Deadzone compare on the registered analog sample.
   assign mag_x   = abs8(ana_q[ANA_W-1:0]);
   assign mag_y   = abs8(ana_q[2*ANA_W-1:ANA_W]);
   assign ana_hit = (mag_x >= ANALOG_DEADZN) || (mag_y >= ANALOG_DEADZN);

   // Input capture, SNAC synchronisers and activity flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dig_q        <= '0;
         ana_q        <= '0;
         mouse_q      <= 1'b0;
         in_valid_q   <= 1'b0;
         mouse_prev   <= 1'b0;
         mouse_primed <= 1'b0;
         v_sync       <= '0;
         h_sync       <= '0;
         v_q          <= 1'b0;
         h_q          <= 1'b0;
         v_prev       <= 1'b0;
         h_prev       <= 1'b0;
         act          <= '0;
      end else begin
         dig_q      <= joystick_digital;
         ana_q      <= joystick_analog;
         mouse_q    <= mouse_toggle;
         in_valid_q <= 1'b1;
         v_sync     <= {v_sync[0], v_clk_in};
         h_sync     <= {h_sync[0], h_clk_in};
         v_q        <= v_sync[1];
         h_q        <= h_sync[1];
         v_prev     <= v_q;
         h_prev     <= h_q;
         // The first real mouse sample only seeds the comparison bit.
         if (in_valid_q) begin
            mouse_prev   <= mouse_q;
            mouse_primed <= 1'b1;
         end
         act[MODE_DIG]   <= |dig_q;
         act[MODE_ANA]   <= ana_hit;
         act[MODE_MOUSE] <= mouse_primed && (mouse_q != mouse_prev);
         act[MODE_SNAC]  <= (v_q != v_prev) || (h_q != h_prev);
      end
   end

endmodule

// File: rtl/trackball_source_arbiter.sv
// Picks which input source drives the trackball emulator mode.
//  clk, reset_n       : clock, synchronous active-low reset
//  auto_en            : 1 = arbitrate on activity, 0 = use mode_forced
//  mode_forced        : mode applied while auto_en is low
//  joystick_digital   : {up,down,left,right}
//  joystick_analog    : {y,x}, two's complement
//  ps2_mouse          : PS/2 packet, bit 24 toggles per packet
//  v_clk_in, h_clk_in : raw SNAC quadrature clocks
//  mode               : 0 dig, 1 analog, 2 mouse, 3 snac
//  owner_valid        : a source currently holds ownership
//  switch_pulse       : one-cycle strobe when mode changes value
module trackball_source_arbiter
   import trackball_pkg::*;
#(
   parameter logic [HOLD_W-1:0] HOLD_CYCLES   = 24'd4_800_000,
   parameter logic [ANA_W-1:0]  ANALOG_DEADZN = 8'd10,
   parameter logic [MODE_W-1:0] DEFAULT_MODE  = 2'b10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 auto_en,
   input  logic [MODE_W-1:0]    mode_forced,
   input  logic [DIG_W-1:0]     joystick_digital,
   input  logic [2*ANA_W-1:0]   joystick_analog,
   input  logic [MOUSE_W-1:0]   ps2_mouse,
   input  logic                 v_clk_in,
   input  logic                 h_clk_in,
   output logic [MODE_W-1:0]    mode,
   output logic                 owner_valid,
   output logic                 switch_pulse
);

   logic [NUM_SRC-1:0] act;
   logic [0:0]         state;
   logic [0:0]         state_n;
   logic [HOLD_W-1:0]  cnt;
   logic [HOLD_W-1:0]  cnt_n;
   logic [MODE_W-1:0]  mode_n;
   logic [MODE_W-1:0]  grant;
   logic               unused_mouse_bits;

   // Only the packet toggle bit matters here.
   assign unused_mouse_bits = ^ps2_mouse[MOUSE_W-2:0];

   trackball_activity_detect #(
      .ANALOG_DEADZN (ANALOG_DEADZN)
   ) u_act (
      .clk              (clk),
      .reset_n          (reset_n),
      .joystick_digital (joystick_digital),
      .joystick_analog  (joystick_analog),
      .mouse_toggle     (ps2_mouse[MOUSE_W-1]),
      .v_clk_in         (v_clk_in),
      .h_clk_in         (h_clk_in),
      .act              (act)
   );

   // Priority encoder: mouse > snac > analog > digital.
   always_comb begin
      grant = MODE_DIG;
      if (act[MODE_MOUSE])     grant = MODE_MOUSE;
      else if (act[MODE_SNAC]) grant = MODE_SNAC;
      else if (act[MODE_ANA])  grant = MODE_ANA;
   end

   // Next state, hold counter and mode.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mode_n  = mode;
      if (!auto_en) begin
         mode_n  = mode_forced;
         state_n = ST_IDLE;
         cnt_n   = '0;
      end else if (state == ST_IDLE) begin
         // Idle keeps the last owner's mode so emulator motion decays.
         if (|act) begin
            state_n = ST_OWNED;
            mode_n  = grant;
            cnt_n   = HOLD_CYCLES;
         end
      end else begin
         // Only the owner's own activity counts; others cannot preempt.
         if (act[mode]) begin
            cnt_n = HOLD_CYCLES;
         end else if (cnt <= HOLD_W'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt - HOLD_W'(1);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         mode         <= DEFAULT_MODE;
         owner_valid  <= 1'b0;
         switch_pulse <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         mode         <= mode_n;
         owner_valid  <= (state_n == ST_OWNED);
         switch_pulse <= (mode_n != mode);
      end
   end

endmodule

// File: tb/tb_trackball_source_arbiter.sv
// Bench for trackball_source_arbiter (HOLD_CYCLES = 16): fixed vector table,
// hand sequences for SNAC/override/reset, then random traffic vs a reference model.
module tb_trackball_source_arbiter;

   localparam int HOLD_I = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        auto_en = 1'b1;
   logic [1:0]  mode_forced = 2'd0;
   logic [3:0]  joystick_digital = 4'd0;
   logic [15:0] joystick_analog = 16'd0;
   logic [24:0] ps2_mouse = 25'd0;
   logic        v_clk_in = 1'b0;
   logic        h_clk_in = 1'b0;
   logic [1:0]  mode;
   logic        owner_valid;
   logic        switch_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   trackball_source_arbiter #(
      .HOLD_CYCLES   (24'd16),
      .ANALOG_DEADZN (8'd10),
      .DEFAULT_MODE  (2'b10)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .auto_en          (auto_en),
      .mode_forced      (mode_forced),
      .joystick_digital (joystick_digital),
      .joystick_analog  (joystick_analog),
      .ps2_mouse        (ps2_mouse),
      .v_clk_in         (v_clk_in),
      .h_clk_in         (h_clk_in),
      .mode             (mode),
      .owner_valid      (owner_valid),
      .switch_pulse     (switch_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: sample history since reset plus an owner/last-activity record.
   logic [3:0]  h_dig[$];
   logic [15:0] h_ana[$];
   bit          h_mouse[$];
   bit          h_h[$];
   bit          h_v[$];
   logic [1:0]  m_mode = 2'd2;
   bit          m_valid = 1'b0;
   logic [1:0]  m_owner = 2'd0;
   int          m_last = 0;
   bit          m_sw = 1'b0;

   function automatic bit outside_dz(input logic [7:0] v);
      int s;
      s = int'($signed(v));
      if (s < 0) s = -s;
      return s >= 10;
   endfunction

   task automatic model_step(input bit rn, input bit ae, input logic [1:0] mf,
                             input logic [3:0] d, input logic [15:0] a,
                             input bit mb, input bit hv, input bit hh);
      bit [3:0]    act;
      int          t;
      logic [1:0]  old;
      logic [15:0] av;
      bit          ph, pv;
      if (!rn) begin
         h_dig.delete(); h_ana.delete(); h_mouse.delete(); h_h.delete(); h_v.delete();
         m_mode = 2'd2; m_valid = 1'b0; m_sw = 1'b0;
         return;
      end
      h_dig.push_back(d); h_ana.push_back(a); h_mouse.push_back(mb);
      h_h.push_back(hh); h_v.push_back(hv);
      t = h_dig.size() - 1;
      act = '0;
      // Digital/analog seen two edges after sampling; mouse needs a previous sample.
      if (t >= 2) begin
         av = h_ana[t-2];
         act[0] = |h_dig[t-2];
         act[1] = outside_dz(av[7:0]) || outside_dz(av[15:8]);
      end
      if (t >= 3) act[2] = (h_mouse[t-2] != h_mouse[t-3]);
      // SNAC carries two extra synchroniser stages; pre-reset level counts as 0.
      if (t >= 4) begin
         ph = (t >= 5) ? h_h[t-5] : 1'b0;
         pv = (t >= 5) ? h_v[t-5] : 1'b0;
         act[3] = (h_h[t-4] != ph) || (h_v[t-4] != pv);
      end
      old = m_mode;
      if (!ae) begin
         m_mode  = mf;
         m_valid = 1'b0;
      end else if (!m_valid) begin
         if (act != 4'd0) begin
            if (act[2])      m_owner = 2'd2;
            else if (act[3]) m_owner = 2'd3;
            else if (act[1]) m_owner = 2'd1;
            else             m_owner = 2'd0;
            m_mode  = m_owner;
            m_valid = 1'b1;
            m_last  = t;
         end
      end else begin
         if (act[m_owner])              m_last  = t;
         else if (t - m_last >= HOLD_I) m_valid = 1'b0;
      end
      m_sw = (m_mode != old);
   endtask

   // One clock: capture the driven inputs, advance the model, settle past the edge.
   task automatic tick();
      bit rn, ae, mb, hv, hh;
      logic [1:0]  mf;
      logic [3:0]  d;
      logic [15:0] a;
      rn = reset_n; ae = auto_en; mf = mode_forced; d = joystick_digital;
      a = joystick_analog; mb = ps2_mouse[24]; hv = v_clk_in; hh = h_clk_in;
      @(posedge clk);
      model_step(rn, ae, mf, d, a, mb, hv, hh);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] em, input logic eov, input logic esp);
      n_cmp++;
      if (mode !== em || owner_valid !== eov || switch_pulse !== esp) begin
         n_bad++;
         $display("FAIL %s @%0t: got mode=%0d owner_valid=%0b switch_pulse=%0b, want mode=%0d owner_valid=%0b switch_pulse=%0b",
                  name, $time, mode, owner_valid, switch_pulse, em, eov, esp);
      end
   endtask

   typedef struct {
      bit          rn;
      logic [3:0]  d;
      logic [15:0] a;
      bit          mb;
      logic [1:0]  em;
      bit          eov;
      bit          esp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rn, input logic [3:0] d, input logic [15:0] a, input bit mb,
                      input logic [1:0] em, input bit eov, input bit esp);
      vec_t v;
      v.rn = rn; v.d = d; v.a = a; v.mb = mb; v.em = em; v.eov = eov; v.esp = esp;
      vecs.push_back(v);
   endtask

   initial begin
      // Vectors (one row per clock) for digital grant/release, mouse priority, deadzone.
      add(1, 4'b0001, 16'h0000, 0, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0000, 0, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0000, 0, 2'd0, 1, 1);
      for (int i = 3; i < 18; i++) add(1, 4'b0000, 16'h0000, 0, 2'd0, 1, 0);
      add(1, 4'b0000, 16'h0000, 0, 2'd0, 0, 0);
      add(1, 4'b0000, 16'h0040, 1, 2'd0, 0, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd0, 0, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd2, 1, 1);
      for (int i = 3; i < 7; i++)  add(1, 4'b0000, 16'h0040, 1, 2'd2, 1, 0);
      for (int i = 7; i < 18; i++) add(1, 4'b0000, 16'h0000, 1, 2'd2, 1, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd2, 0, 0);
      add(0, 4'b0000, 16'h0000, 1, 2'd2, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 4'b0000, 16'hF709, 1, 2'd2, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 4'b0000, 16'h0000, 1, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0080, 1, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd2, 0, 0);
      add(1, 4'b0000, 16'h0000, 1, 2'd1, 1, 1);
      for (int i = 0; i < 3; i++) add(1, 4'b0000, 16'h0000, 1, 2'd1, 1, 0);

      // Reset, then 100 quiet cycles.
      reset_n = 1'b0;
      tick(); tick();
      check("reset", 2'd2, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("quiet", 2'd2, 1'b0, 1'b0);
      end

      foreach (vecs[i]) begin
         reset_n          = vecs[i].rn;
         joystick_digital = vecs[i].d;
         joystick_analog  = vecs[i].a;
         ps2_mouse[24]    = vecs[i].mb;
         tick();
         check($sformatf("vec%0d", i), vecs[i].em, vecs[i].eov, vecs[i].esp);
      end
      reset_n = 1'b1; joystick_digital = '0; joystick_analog = '0;

      // SNAC: toggles sampled at 0,8,16,24; grant at 4, release 16 after the edge-24 activity.
      reset_n = 1'b0;
      tick();
      check("snac reset", 2'd2, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      for (int c = 0; c <= 50; c++) begin
         if (c < 32 && c % 8 == 0) h_clk_in = ~h_clk_in;
         tick();
         check($sformatf("snac c%0d", c), (c >= 4) ? 2'd3 : 2'd2,
               (c >= 4 && c < 44), (c == 4));
      end

      // Override and reset while mouse owns.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      ps2_mouse[24] = ~ps2_mouse[24];
      tick(); tick(); tick();
      check("mouse regrant same mode", 2'd2, 1'b1, 1'b0);
      auto_en = 1'b0; mode_forced = 2'd1;
      tick();
      check("forced", 2'd1, 1'b0, 1'b1);
      auto_en = 1'b1;
      tick();
      check("auto resume", 2'd1, 1'b0, 1'b0);
      ps2_mouse[24] = ~ps2_mouse[24];
      tick(); tick(); tick();
      check("mouse grant", 2'd2, 1'b1, 1'b1);
      tick();
      reset_n = 1'b0;
      tick();
      check("reset owned", 2'd2, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("post reset", 2'd2, 1'b0, 1'b0);
      end

      // Random traffic against the reference model.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] sx, sy;
         reset_n = ($urandom_range(0, 399) != 0);
         if ($urandom_range(0, 149) == 0) auto_en = ~auto_en;
         mode_forced = 2'($urandom_range(0, 3));
         joystick_digital = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 39) == 0) begin
            joystick_analog = 16'($urandom);
         end else begin
            sx = 8'($urandom_range(0, 18)) - 8'd9;
            sy = 8'($urandom_range(0, 18)) - 8'd9;
            joystick_analog = {sy, sx};
         end
         if ($urandom_range(0, 39) == 0) ps2_mouse[24] = ~ps2_mouse[24];
         ps2_mouse[23:0] = 24'($urandom);
         if ($urandom_range(0, 39) == 0) h_clk_in = ~h_clk_in;
         if ($urandom_range(0, 59) == 0) v_clk_in = ~v_clk_in;
         tick();
         check("random", m_mode, m_valid, m_sw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
